// File: rtl/layer_pixel_fetch.sv
// layer_pixel_fetch: per-pixel memory-read responder for one layer.
// Text layers read a glyph bit from Flash, and that bit gates the RAM colour read.
// Sprite layers read RAM only. A one-byte Flash cache lets consecutive glyph
// pixels that fall in the same byte skip the Flash access.
module layer_pixel_fetch #(
  parameter int PIXEL_W        = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               readRamEn,
  input  logic               readFlashEn,
  input  logic [26:0]        ramBaseBytes,
  input  logic [26:0]        ramAddressOffsetBytes,
  input  logic [26:0]        flashBaseBytes,
  input  logic [29:0]        flashAddressOffsetBits,
  output logic               rdy,
  output logic               pixelValid,
  output logic [PIXEL_W-1:0] pixelData,
  output logic               pixelOpaque,
  output logic               fetchError,
  output logic               ram_read,
  output logic [25:0]        ram_address,
  input  logic               ram_waitrequest,
  input  logic               ram_readdatavalid,
  input  logic [PIXEL_W-1:0] ram_readdata,
  output logic               flash_read,
  output logic [26:0]        flash_address,
  input  logic               flash_waitrequest,
  input  logic               flash_readdatavalid,
  input  logic [7:0]         flash_readdata
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_FLASH_REQ  = 3'd1;
  localparam logic [2:0] S_FLASH_WAIT = 3'd2;
  localparam logic [2:0] S_RAM_REQ    = 3'd3;
  localparam logic [2:0] S_RAM_WAIT   = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               ram_en_q;
  logic [2:0]         bit_idx_q;
  logic [26:0]        byte_addr_q;
  logic [25:0]        ram_addr_q;
  logic               cache_valid;
  logic [26:0]        cache_tag;
  logic [7:0]         cache_data;
  logic [PIXEL_W-1:0] data_q;
  logic               opaque_q;
  logic               error_q;

  logic [26:0]        start_byte;
  logic [25:0]        start_ram_word;
  logic               cache_hit;
  logic               hit_bit;
  logic               fetched_bit;
  logic               cnt_expired;

  // Address arithmetic for the incoming request; the RAM word address is the
  // upper 26 bits of the 27-bit byte sum, formed as word sum plus low-bit carry.
  always_comb begin
    start_byte     = flashBaseBytes + flashAddressOffsetBits[29:3];
    start_ram_word = ramBaseBytes[26:1] + ramAddressOffsetBytes[26:1]
                   + {25'b0, ramBaseBytes[0] & ramAddressOffsetBytes[0]};
    cache_hit      = cache_valid && (cache_tag == start_byte);
    hit_bit        = cache_data[~flashAddressOffsetBits[2:0]];
    fetched_bit    = flash_readdata[~bit_idx_q];
    cnt_expired    = (cnt == CNT_LAST);
  end

  // Request sequencing, timeout counting and Flash byte cache.
  // cnt defaults to zero so it clears on every state change and only counts
  // while a port access is stalled in the same state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      ram_en_q    <= 1'b0;
      bit_idx_q   <= '0;
      byte_addr_q <= '0;
      ram_addr_q  <= '0;
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
      data_q      <= '0;
      opaque_q    <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      cnt <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ram_en_q    <= readRamEn;
            bit_idx_q   <= flashAddressOffsetBits[2:0];
            byte_addr_q <= start_byte;
            ram_addr_q  <= start_ram_word;
            data_q      <= '0;
            opaque_q    <= 1'b0;
            error_q     <= 1'b0;
            if (readFlashEn) begin
              if (!cache_hit)
                state <= S_FLASH_REQ;
              else if (hit_bit && readRamEn)
                state <= S_RAM_REQ;
              else
                state <= S_DONE;
            end else if (readRamEn) begin
              state <= S_RAM_REQ;
            end else begin
              state <= S_DONE;
            end
          end
        end
        S_FLASH_REQ: begin
          if (!flash_waitrequest) begin
            state <= S_FLASH_WAIT;
          end else if (cnt_expired) begin
            state   <= S_DONE;
            error_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FLASH_WAIT: begin
          if (flash_readdatavalid) begin
            cache_valid <= 1'b1;
            cache_tag   <= byte_addr_q;
            cache_data  <= flash_readdata;
            state       <= (fetched_bit && ram_en_q) ? S_RAM_REQ : S_DONE;
          end else if (cnt_expired) begin
            state   <= S_DONE;
            error_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RAM_REQ: begin
          if (!ram_waitrequest) begin
            state <= S_RAM_WAIT;
          end else if (cnt_expired) begin
            state   <= S_DONE;
            error_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RAM_WAIT: begin
          if (ram_readdatavalid) begin
            data_q   <= ram_readdata;
            opaque_q <= 1'b1;
            state    <= S_DONE;
          end else if (cnt_expired) begin
            state   <= S_DONE;
            error_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status, strobes and result are direct decodes of state and registers.
  always_comb begin
    rdy           = (state == S_IDLE);
    pixelValid    = (state == S_DONE);
    ram_read      = (state == S_RAM_REQ);
    flash_read    = (state == S_FLASH_REQ);
    ram_address   = ram_addr_q;
    flash_address = byte_addr_q;
    pixelData     = data_q;
    pixelOpaque   = opaque_q;
    fetchError    = error_q;
  end

endmodule
